fifo_rd_stream_adapter: RTL

//  Drains the synchronous FIFO read port (r_en / data_out / empty) and presents the words as a

---
 rtl/fifo_rd_stream_if.sv | 22 ++
 rtl/fifo_rd_stream_adapter.sv | 48 ++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus downstream valid/ready stream bundle.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LVL_W      = 2
);
  logic                  en;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [LVL_W-1:0]      buf_level;
  modport master (
    input  en, fifo_data_out, fifo_empty, m_ready,
    output fifo_r_en, m_valid, m_data, buf_level
  );
  modport slave (
    output en, fifo_data_out, fifo_empty, m_ready,
    input  fifo_r_en, m_valid, m_data, buf_level
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a 1-cycle-latency FIFO read port into a valid/ready stream
// through a credit-controlled circular skid buffer.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 3,
  parameter int LVL_W      = 2
) (
  input logic              clk,
  input logic              rst_n,
  fifo_rd_stream_if.master bus
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0]  LAST  = PW'(BUF_DEPTH - 1);
  localparam logic [LVL_W:0] DEPTH = (LVL_W + 1)'(BUF_DEPTH);
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  inflight_q, pop;
  // Credit counts the in-flight word so an arriving word always has a free slot.
  assign bus.fifo_r_en = rst_n && bus.en && !bus.fifo_empty &&
                         (({1'b0, count_q} + (LVL_W + 1)'(inflight_q)) < DEPTH);
  assign bus.m_valid   = count_q != '0;
  assign bus.m_data    = buf_q[rd_ptr_q];
  assign bus.buf_level = count_q;
  always_comb begin
    pop      = bus.m_valid && bus.m_ready;
    wr_ptr_d = !inflight_q ? wr_ptr_q : (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1);
    rd_ptr_d = !pop ? rd_ptr_q : (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1);
    count_d  = count_q + LVL_W'(inflight_q) - LVL_W'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= bus.fifo_r_en;
      if (inflight_q) buf_q[wr_ptr_q] <= bus.fifo_data_out;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && !pop && count_q == DEPTH[LVL_W-1:0]));
endmodule
